// File: rtl/dispatch_pkg.sv
// Shared definitions for the unit dispatch scheduler and related arbiters.
package dispatch_pkg;

  localparam int N_DEF           = 13;
  localparam int PEND_W_DEF      = 4;
  localparam int ACK_TIMEOUT_DEF = 16;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  // Width of a counter that must be able to hold the value 'timeout'.
  function automatic int ack_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/unit_dispatch_scheduler_if.sv
// Bundle between the start source / unit bank and the dispatch scheduler.
//
// Handshake: start_out[u] is a single-cycle pulse offering one job to unit u,
// issued only while avail[u] is high (the unit's "ready"). The unit accepts
// by dropping avail[u]; the drop may occur in the pulse cycle itself or any
// later cycle. A unit that never drops avail is fenced off via fault_mask and
// its job goes back into the pending count.
interface unit_dispatch_scheduler_if
  import dispatch_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int PEND_W = PEND_W_DEF
);

  logic              start_in;
  logic [N-1:0]      avail;
  logic              clr_fault;
  logic [N-1:0]      start_out;
  logic [PEND_W-1:0] pending;
  logic              overflow;
  logic [N-1:0]      fault_mask;
  logic              idle;

  modport master (
    output start_in, avail, clr_fault,
    input  start_out, pending, overflow, fault_mask, idle
  );

  modport slave (
    input  start_in, avail, clr_fault,
    output start_out, pending, overflow, fault_mask, idle
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping.
module rr_pick #(
  parameter int N     = 13,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  int               cand;
  logic [PTR_W-1:0] cidx;

  // Scan ptr+1 .. ptr+N modulo N; the first requester found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      cidx = PTR_W'(cand);
      if (!any && req[cidx]) begin
        any         = 1'b1;
        grant[cidx] = 1'b1;
        grant_idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/unit_dispatch_scheduler.sv
// Queues job requests and dispatches them one at a time, round-robin, to
// idle units; units that never acknowledge are masked and the job requeued.
module unit_dispatch_scheduler
  import dispatch_pkg::*;
#(
  parameter int N           = N_DEF,
  parameter int PEND_W      = PEND_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                       MHz10,
  input  logic                       nrst,
  unit_dispatch_scheduler_if.slave   bus,
  output state_t                     state_dbg
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACK_W = ack_cnt_w(ACK_TIMEOUT);
  localparam logic [PEND_W+1:0] PEND_MAX_X = {2'b00, {PEND_W{1'b1}}};

  state_t            state_q, state_d;
  // ptr doubles as the latched grant index: it is updated only on dispatch,
  // so while waiting for the acknowledge it names the unit in flight.
  logic [PTR_W-1:0]  ptr_q;
  logic [ACK_W-1:0]  ack_cnt_q;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic [N-1:0]      fault_q, fault_d;
  logic [N-1:0]      start_q, start_d;
  logic              ovf_q, ovf_d;

  logic [N-1:0]      elig, pick_grant;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;
  logic              dispatch, acked, timeout;
  logic [PEND_W+1:0] pend_base;

  assign elig = bus.avail & ~fault_q;

  rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
    .req       (elig),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // State register.
  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: leave IDLE on dispatch, leave WAIT_ACK on ack or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (dispatch) state_d = WAIT_ACK;
      WAIT_ACK: if (acked || timeout) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM decodes and next values of the datapath registers.
  always_comb begin
    dispatch = (state_q == IDLE) && (pending_q != '0) && pick_any;
    acked    = (state_q == WAIT_ACK) && !bus.avail[ptr_q];
    timeout  = (state_q == WAIT_ACK) && bus.avail[ptr_q] &&
               (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1));
    start_d  = dispatch ? pick_grant : '0;

    // Dispatch and requeue never coincide (different states); a requeue at
    // saturation is silently absorbed, only a lost request raises overflow.
    pend_base = {2'b00, pending_q} + (PEND_W + 2)'(timeout)
                - (PEND_W + 2)'(dispatch);
    if (pend_base > PEND_MAX_X) pend_base = PEND_MAX_X;
    ovf_d     = bus.start_in && (pend_base == PEND_MAX_X);
    pending_d = pend_base[PEND_W-1:0] + PEND_W'(bus.start_in && !ovf_d);

    // Clear first so a timeout in the same cycle still marks its unit.
    fault_d = (bus.clr_fault ? '0 : fault_q) |
              (timeout ? (N'(1) << ptr_q) : '0);
  end

  // Datapath registers.
  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      ptr_q     <= PTR_W'(N - 1);
      ack_cnt_q <= '0;
      pending_q <= '0;
      fault_q   <= '0;
      start_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      fault_q   <= fault_d;
      start_q   <= start_d;
      ovf_q     <= ovf_d;
      if (dispatch) begin
        ptr_q     <= pick_idx;
        ack_cnt_q <= '0;
      end else if (state_q == WAIT_ACK) begin
        ack_cnt_q <= ack_cnt_q + ACK_W'(1);
      end
    end
  end

  assign bus.start_out  = start_q;
  assign bus.pending    = pending_q;
  assign bus.overflow   = ovf_q;
  assign bus.fault_mask = fault_q;
  assign bus.idle       = (state_q == IDLE) && (pending_q == '0);
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_unit_dispatch_scheduler.sv
// Bench for unit_dispatch_scheduler: directed scenarios then random traffic,
// checked every cycle against a job-level reference model.
module tb_unit_dispatch_scheduler;
  import dispatch_pkg::*;

  localparam int N           = 13;
  localparam int PEND_W      = 4;
  localparam int ACK_TIMEOUT = 16;
  localparam int PMAX        = 15;
  localparam logic [N-1:0] ALL = 13'h1FFF;

  // ---------------- clock / reset ----------------
  logic   MHz10 = 1'b0;
  logic   nrst  = 1'b0;
  state_t state_dbg;

  always #50 MHz10 = ~MHz10;

  unit_dispatch_scheduler_if #(.N(N), .PEND_W(PEND_W)) bus ();

  unit_dispatch_scheduler #(.N(N), .PEND_W(PEND_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .MHz10     (MHz10),
    .nrst      (nrst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Job view: a count of queued jobs, a set of faulted units, at most one
  // job in flight (unit + cycles waited), and the last unit served.
  int           m_pending;
  bit [N-1:0]   m_fault;
  bit           m_busy;
  int           m_unit;
  int           m_wait;
  int           m_last;
  bit [N-1:0]   m_start;
  bit           m_ovf;

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic bit bit_at(input logic [N-1:0] v, input int i);
    return |(v & onehot(i));
  endfunction

  task automatic model_reset();
    m_pending = 0;
    m_fault   = '0;
    m_busy    = 1'b0;
    m_unit    = 0;
    m_wait    = 0;
    m_last    = N - 1;
    m_start   = '0;
    m_ovf     = 1'b0;
    exp_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int         p, u;
    bit         granted, requeue;
    bit [N-1:0] newf;
    granted = 1'b0;
    requeue = 1'b0;
    m_start = '0;
    newf    = bus.clr_fault ? '0 : m_fault;
    if (m_busy) begin
      if (!bit_at(bus.avail, m_unit)) begin
        m_busy = 1'b0;
      end else begin
        m_wait++;
        if (m_wait >= ACK_TIMEOUT) begin
          newf    = newf | onehot(m_unit);
          requeue = 1'b1;
          m_busy  = 1'b0;
        end
      end
    end else if (m_pending > 0) begin
      for (int s = 1; s <= N; s++) begin
        u = (m_last + s) % N;
        if (!granted && bit_at(bus.avail, u) && !bit_at(m_fault, u)) begin
          granted = 1'b1;
          m_last  = u;
          m_unit  = u;
          m_busy  = 1'b1;
          m_wait  = 0;
          m_start = onehot(u);
        end
      end
      if (granted) exp_q.push_back(m_start);
    end
    p = m_pending - int'(granted) + int'(requeue);
    if (p > PMAX) p = PMAX;
    m_ovf = 1'b0;
    if (bus.start_in) begin
      if (p < PMAX) p++;
      else m_ovf = 1'b1;
    end
    m_pending = p;
    m_fault   = newf;
  endtask

  task automatic check_all();
    logic [N-1:0] e;
    chk("start_out",  32'(bus.start_out),  32'(m_start));
    chk("pending",    32'(bus.pending),    32'(m_pending));
    chk("overflow",   32'(bus.overflow),   32'(m_ovf));
    chk("fault_mask", 32'(bus.fault_mask), 32'(m_fault));
    chk("idle",       32'(bus.idle),       32'(!m_busy && m_pending == 0));
    if (bus.start_out != '0) begin
      if (exp_q.size() == 0) begin
        chk("grant_unexpected", 32'(bus.start_out), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("grant_order", 32'(bus.start_out), 32'(e));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit s, input logic [N-1:0] a, input bit c);
    bus.start_in  = s;
    bus.avail     = a;
    bus.clr_fault = c;
  endtask

  task automatic cycle();
    model_step();
    @(posedge MHz10);
    #1;
    check_all();
  endtask

  // Called just after a clock edge; releases reset well before the next one.
  task automatic do_reset();
    drive(1'b0, '0, 1'b0);
    nrst = 1'b0;
    model_reset();
    #1;
    check_all();
    #39;
    nrst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0] got[$];
  logic [N-1:0] a;
  logic [N-1:0] sticky;

  initial begin
    drive(1'b0, '0, 1'b0);
    model_reset();
    #130;
    check_all();
    chk("reset_state", 32'(state_dbg), 32'(IDLE));
    nrst = 1'b1;

    // 1: single request, grant two cycles later, ack by dropping avail[0].
    drive(1'b1, ALL, 1'b0);
    cycle();
    drive(1'b0, ALL, 1'b0);
    cycle();
    chk("t1_start_out", 32'(bus.start_out), 32'h0001);
    drive(1'b0, ALL & ~13'h0001, 1'b0);
    cycle();
    chk("t1_idle", 32'(bus.idle), 32'd1);
    chk("t1_pending", 32'(bus.pending), 32'd0);

    // 2: three back-to-back requests rotate over units 0,1,2.
    do_reset();
    got.delete();
    for (int c = 0; c < 14; c++) begin
      a = ALL & ~bus.start_out;
      drive(c < 3, a, 1'b0);
      cycle();
      if (bus.start_out != '0) got.push_back(bus.start_out);
    end
    chk("t2_grant_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("t2_grant0", 32'(got[0]), 32'h0001);
      chk("t2_grant1", 32'(got[1]), 32'h0002);
      chk("t2_grant2", 32'(got[2]), 32'h0004);
    end

    // 3: saturation with no unit available.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, '0, 1'b0);
      cycle();
      chk("t3_pending", 32'(bus.pending), 32'((i < PMAX) ? i : PMAX));
      chk("t3_overflow", 32'(bus.overflow), 32'(i >= 16));
    end
    drive(1'b0, '0, 1'b0);
    cycle();
    chk("t3_overflow_end", 32'(bus.overflow), 32'd0);

    // 4: unit 2 never acknowledges -> masked, job requeued.
    do_reset();
    drive(1'b1, 13'h0004, 1'b0);
    cycle();
    drive(1'b0, 13'h0004, 1'b0);
    cycle();
    chk("t4_grant", 32'(bus.start_out), 32'h0004);
    for (int i = 0; i < ACK_TIMEOUT; i++) begin
      cycle();
      if (i == ACK_TIMEOUT - 2) chk("t4_not_yet", 32'(bus.fault_mask), 32'd0);
    end
    chk("t4_fault", 32'(bus.fault_mask), 32'h0004);
    chk("t4_requeue", 32'(bus.pending), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_no_regrant", 32'(bus.start_out), 32'd0);
    end
    drive(1'b0, 13'h0004, 1'b1);
    cycle();
    chk("t4_cleared", 32'(bus.fault_mask), 32'd0);
    drive(1'b0, 13'h0004, 1'b0);
    cycle();
    chk("t4_regrant", 32'(bus.start_out), 32'h0004);
    // clr_fault on the timeout cycle: the timeout still marks unit 2.
    for (int i = 0; i < ACK_TIMEOUT; i++) begin
      drive(1'b0, 13'h0004, i == ACK_TIMEOUT - 1);
      cycle();
    end
    chk("t4_clr_vs_timeout", 32'(bus.fault_mask), 32'h0004);

    // 5: clear faults, dispatch elsewhere, then async reset mid-wait.
    drive(1'b0, ALL, 1'b1);
    cycle();
    chk("t5_grant3", 32'(bus.start_out), 32'h0008);
    drive(1'b0, ALL, 1'b0);
    cycle();
    chk("t5_waiting", 32'(state_dbg), 32'(WAIT_ACK));
    #20;
    nrst = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_start", 32'(bus.start_out), 32'd0);
    chk("t5_rst_pending", 32'(bus.pending), 32'd0);
    chk("t5_rst_overflow", 32'(bus.overflow), 32'd0);
    chk("t5_rst_fault", 32'(bus.fault_mask), 32'd0);
    chk("t5_rst_state", 32'(state_dbg), 32'(IDLE));
    #30;
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, ALL, 1'b0);
      cycle();
    end
    chk("t5_not_requeued", 32'(bus.pending), 32'd0);

    // 6: random traffic in three avail regimes.
    sticky = ALL;
    for (int c = 0; c < 600; c++) begin
      case ((c / 100) % 3)
        0:       a = N'($urandom);
        1: begin
          if (c % 20 == 0) sticky = N'($urandom) | N'($urandom);
          a = sticky;
        end
        default: a = N'($urandom) & N'($urandom);
      endcase
      drive($urandom_range(0, 3) == 0, a, $urandom_range(0, 40) == 0);
      cycle();
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
